// File: rtl/pipe_reg.sv
// DEPTH-stage, WIDTH-bit enabled delay line with per-stage valid bits and an occupancy count.
// Define PIPE_REG_FLUSH_EN to make the flush input functional; otherwise flush is ignored.
module pipe_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [WIDTH-1:0]               data,
  input  logic                           valid_in,
  input  logic                           flush,
  output logic [WIDTH-1:0]               q,
  output logic                           valid_out,
  output logic [$clog2(DEPTH+1)-1:0]     occ
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             flush_act;

`ifdef PIPE_REG_FLUSH_EN
  assign flush_act = flush;
`else
  // Port kept for a uniform interface; tied off so no flush logic remains.
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  // Entering and leaving items on the same edge cancel out.
  always_comb begin
    occ_d = occ_q;
    unique case ({valid_in, valid_q[DEPTH-1]})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else if (flush_act) begin
      // Data registers deliberately hold; only the qualifiers are dropped.
      valid_q <= '0;
      occ_q   <= '0;
    end else if (en) begin
      data_q[0]  <= data;
      valid_q[0] <= valid_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
      occ_q <= occ_d;
    end
  end

  assign q         = data_q[DEPTH-1];
  assign valid_out = valid_q[DEPTH-1];
  assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5); follows PIPE_REG_FLUSH_EN.
module tb_pipe_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, valid_in = 1'b0, flush = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] q;
  logic       valid_out;
  logic [2:0] occ;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .data      (data),
    .valid_in  (valid_in),
    .flush     (flush),
    .q         (q),
    .valid_out (valid_out),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] eq, input logic ev, input logic [2:0] eo);
    check({name, ".q"}, {24'h0, q}, {24'h0, eq});
    check({name, ".valid_out"}, {31'h0, valid_out}, {31'h0, ev});
    check({name, ".occ"}, {29'h0, occ}, {29'h0, eo});
  endtask

  task automatic chk_vo(input string name, input logic ev, input logic [2:0] eo);
    check({name, ".valid_out"}, {31'h0, valid_out}, {31'h0, ev});
    check({name, ".occ"}, {29'h0, occ}, {29'h0, eo});
  endtask

  // Drive one edge, update the expected-output queue, settle just after the edge.
  task automatic cyc(input logic r, input logic f, input logic e, input logic vi,
                     input logic [7:0] d);
    @(negedge clk);
    reset = r; flush = f; en = e; valid_in = vi; data = d;
    @(posedge clk);
    if (r) sb.delete();
`ifdef PIPE_REG_FLUSH_EN
    else if (f) sb.delete();
`endif
    else if (e && vi) sb.push_back(d);
    #1;
  endtask

  // Monitor: every valid output must match the oldest expected item.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb.unexpected_valid", {24'h0, q}, 32'hFFFF_FFFF);
      end else begin
        check("sb.q", {24'h0, q}, {24'h0, sb.pop_front()});
      end
    end
  end

  logic [2:0] occ_stream [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [2:0] occ_bub    [8]  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
  logic       vo_bub     [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    // Reset with random side inputs
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
    end
    chk("reset", 8'hA5, 1'b0, 3'd0);

    // Streaming 01..06 then drain
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, (i < 6), (i < 6) ? 8'(i + 1) : 8'h00);
      check($sformatf("stream.occ%0d", i), {29'h0, occ}, {29'h0, occ_stream[i]});
      if (i == 3) chk("stream.first", 8'h01, 1'b1, 3'd4);
    end

    // Stall with 10,11 loaded (stage 3 holds 00 from the drain)
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      chk($sformatf("stall%0d", i), 8'h00, 1'b0, 3'd2);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_vo("resume1", 1'b0, 3'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("resume2", 8'h10, 1'b1, 3'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("resume3", 8'h11, 1'b1, 3'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_vo("resume4", 1'b0, 3'd0);

    // Bubbles 1,0,1,0
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, (i < 4) && (i % 2 == 0), (i < 4) ? 8'(8'h20 + i) : 8'h00);
      chk_vo($sformatf("bubble%0d", i), vo_bub[i], occ_bub[i]);
      if (i == 3) check("bubble.q20", {24'h0, q}, 32'h20);
      if (i == 4) check("bubble.q21", {24'h0, q}, 32'h21);
      if (i == 5) check("bubble.q22", {24'h0, q}, 32'h22);
    end

    // Flush with a full pipe
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h30 + i));
    chk("full", 8'h30, 1'b1, 3'd4);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
`ifdef PIPE_REG_FLUSH_EN
    chk("flush", 8'h30, 1'b0, 3'd0);
`else
    chk("noflush", 8'h31, 1'b1, 3'd4);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_vo("flush.drain", 1'b0, 3'd0);

    // Reset mid-operation with flush and en also high
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h40 + i));
    chk_vo("pre_reset", 1'b0, 3'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    chk("mid_reset", 8'hA5, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h60);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_reset", 8'h60, 1'b1, 3'd1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    @(negedge clk);
    #1;
    check("sb.empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised pipeline register: a DEPTH-stage, WIDTH-bit delay line of enabled flip-flops with per-stage valid tracking, stall control, optional flush and an occupancy count. It generalises the single-bit enabled flip-flop to the multi-bit, multi-stage retiming element used between datapath blocks, where a stall must freeze every stage at once.

## Interface
- WIDTH, 8: data bits per stage (≥1)
- DEPTH, 4: number of stages, equal to latency in enabled cycles (≥1)
- RESET_VAL, 0: value loaded into every stage's data register on reset (WIDTH bits)

- clk  in  1  rising-edge clock; only clock in the block
- reset  in  1  synchronous, active-high reset
- en  in  1  advance enable; 0 = stall, every stage holds
- data  in  WIDTH  stage-0 input data
- valid_in  in  1  qualifies data
- flush  in  1  invalidate all stages (functional only with PIPE_REG_FLUSH_EN)
- q  out  WIDTH  data of last stage (stage DEPTH-1)
- valid_out  out  1  valid bit of last stage
- occ  out  $clog2(DEPTH+1)  number of stages currently holding a valid bit

## Operation
- Storage: stage[0..DEPTH-1], each {WIDTH data, 1 valid}, all registered; q/valid_out driven directly from stage[DEPTH-1], no combinational path from inputs.
- Priority per rising edge: reset > flush > en > hold.
- reset=1: every stage data=RESET_VAL, valid=0; occ=0.
- flush=1 (macro defined, reset=0): all valid bits cleared, data registers hold, occ=0; en and valid_in that cycle ignored (incoming item dropped).
- en=1 (no reset/flush): stage[0] ← {data, valid_in}; stage[i] ← stage[i-1] for i=1..DEPTH-1; the item in stage[DEPTH-1] leaves.
- en=0: all stages, q, valid_out, occ hold.
- Data captured on every enabled edge irrespective of valid_in; consumers must qualify q with valid_out.
- occ update on enabled edge: occ ← occ + valid_in − valid_out(pre-edge). Width $clog2(DEPTH+1) guarantees no overflow; occ ∈ [0, DEPTH] always. Increment and decrement in the same edge cancel (occ unchanged).
- DEPTH=1: single enabled register with valid; occ is 1 bit.

## Timing
- Reset values: q=RESET_VAL, valid_out=0, occ=0, visible after the first rising edge with reset=1.
- Latency: item presented at edge N with en=1 appears on q after the DEPTH-th enabled edge, i.e. at N+DEPTH−1 when en stays high; each stall cycle adds one cycle.
- Throughput: one item per enabled cycle, no bubbles inserted.
- Reset mid-stream: all in-flight items lost in one cycle; first post-reset enabled edge loads stage[0] normally.
- Flush and reset asserted together: reset behaviour (data also forced to RESET_VAL).
- Inputs sampled only at rising edge; changes between edges have no effect.

## Configuration
- PIPE_REG_FLUSH_EN defined: flush port functional as above.
- Not defined: flush port present but ignored; no flush logic synthesised; only reset clears valid bits.

## Test plan
(WIDTH=8, DEPTH=4, RESET_VAL=8'hA5, macro defined unless noted)
- Reset: hold reset=1 two cycles with random data/en -> q=8'hA5, valid_out=0, occ=0.
- Streaming: en=1, push 8'h01..8'h06 with valid_in=1 on consecutive edges -> 8'h01 on q with valid_out=1 after 4th edge, then 8'h02..8'h06 on consecutive cycles; occ rises 1,2,3,4 and stays 4.
- Stall: after loading 8'h10,8'h11 set en=0 for 3 cycles with data=8'hFF -> q, valid_out, occ unchanged; resume en=1 -> 8'h10 reaches q after 2 more enabled edges, 8'hFF never appears valid.
- Bubbles: en=1, valid_in pattern 1,0,1,0 with data 8'h20..8'h23 -> valid_out pattern 1,0,1,0 starting 4th edge with q=8'h20 and 8'h22 on valid cycles; occ peaks at 2.
- Flush: pipe full (occ=4), assert flush with en=1, valid_in=1, data=8'h77 -> next edge valid_out=0, occ=0, 8'h77 never output valid; with macro undefined same stimulus -> pipe advances normally, occ stays 4.
- Reset mid-operation: occ=3, assert reset with flush=1 and en=1 -> q=8'hA5, valid_out=0, occ=0 after that edge.
